// File: rtl/sync0_controller.sv
// SYNC0 front end: conditions the ESC SYNC0 pin, issues the one-shot SYNC that zeroes
// the ultrasound time base, then watches the SYNC0 period to report lock or loss of sync.
module sync0_controller #(
  parameter int SYS_CLK_FREQ = 20480000,
  parameter int SYNC0_FREQ   = 2000,
  parameter int TOL          = 4,
  parameter int LOCK_COUNT   = 4,
  localparam int SYNC0_CYCLE = SYS_CLK_FREQ / SYNC0_FREQ,
  localparam int PW          = $clog2(2 * SYNC0_CYCLE) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          SYNC0_RAW,
  input  logic          SYNC_REQ,
  output logic          SYNC,
  output logic          LOCKED,
  output logic          SYNC_ERR,
  output logic [PW-1:0] PERIOD
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [PW-1:0] CYCLE_LO    = PW'(SYNC0_CYCLE - TOL);
  localparam logic [PW-1:0] CYCLE_HI    = PW'(SYNC0_CYCLE + TOL);
  localparam logic [PW-1:0] TIMEOUT_CNT = PW'(2 * SYNC0_CYCLE - 1);
  localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CHECK,
    S_LOCK,
    S_ERROR
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      sync_q_reg;
  logic [PW-1:0]   pcnt_reg;
  logic [PW-1:0]   period_reg;
  logic [GW-1:0]   good_cnt_reg, good_cnt_next;
  logic            sync_reg, sync_next;
  logic            locked_reg;
  logic            err_reg, err_next;
  logic            rise;
  logic [PW-1:0]   measured;
  logic            in_tol;
  logic            timeout;

  assign rise     = sync_q_reg[1] & ~sync_q_reg[2];
  assign measured = pcnt_reg + 1'b1;
  assign in_tol   = (measured >= CYCLE_LO) && (measured <= CYCLE_HI);
  assign timeout  = !rise && (pcnt_reg == TIMEOUT_CNT);

  // A request always beats an edge, except in ARMED where the edge is what we were waiting for.
  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    sync_next     = 1'b0;
    err_next      = err_reg;
    case (state_reg)
      S_IDLE: begin
        if (SYNC_REQ) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (rise) begin
          state_next    = S_CHECK;
          sync_next     = 1'b1;
          good_cnt_next = '0;
        end
      end
      S_CHECK: begin
        if (SYNC_REQ) begin
          state_next = S_ARMED;
        end else if (rise && in_tol) begin
          good_cnt_next = good_cnt_reg + 1'b1;
          if (good_cnt_reg == GOOD_LAST) state_next = S_LOCK;
        end else if (rise || timeout) begin
          state_next = S_ERROR;
        end
      end
      S_LOCK: begin
        if (SYNC_REQ) state_next = S_ARMED;
        else if ((rise && !in_tol) || timeout) state_next = S_ERROR;
      end
      S_ERROR: begin
        if (SYNC_REQ) state_next = S_ARMED;
      end
      default: state_next = S_IDLE;
    endcase
    if (SYNC_REQ) err_next = 1'b0;
    else if ((state_next == S_ERROR) && (state_reg != S_ERROR)) err_next = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      sync_q_reg   <= '0;
      pcnt_reg     <= '0;
      period_reg   <= '0;
      good_cnt_reg <= '0;
      sync_reg     <= 1'b0;
      locked_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      sync_q_reg <= {sync_q_reg[1:0], SYNC0_RAW};
      if (rise) pcnt_reg <= '0;
      else if (pcnt_reg != '1) pcnt_reg <= pcnt_reg + 1'b1;
      if (rise) period_reg <= measured;
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
      sync_reg     <= sync_next;
      locked_reg   <= (state_next == S_LOCK);
      err_reg      <= err_next;
    end
  end

  assign SYNC     = sync_reg;
  assign LOCKED   = locked_reg;
  assign SYNC_ERR = err_reg;
  assign PERIOD   = period_reg;

endmodule
